// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction-side input channel and
// immediate-side output channel. The block uses the slave modport.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      inst;
  logic [2:0]       imm_type;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  ext_imm;
  logic [TAG_W-1:0] out_tag;
  logic             imm_err;

  modport master (
    output in_valid, inst, imm_type, in_tag, out_ready,
    input  in_ready, out_valid, ext_imm, out_tag, imm_err
  );

  modport slave (
    input  in_valid, inst, imm_type, in_tag, out_ready,
    output in_ready, out_valid, ext_imm, out_tag, imm_err
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I immediate decoder/sign-extender with valid/ready output stage.
// Optional CSR zimm (Z-type) decode is enabled by defining IMM_GEN_ZIMM_EN.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter bit SKID  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  imm_gen_pipe_if.slave       bus,
  output logic [15:0]         err_count
);

  // Fill with the sign bit, then overwrite the low field; {err, imm}.
  function automatic logic [XLEN:0] decode_imm(input logic [31:7] inst, input logic [2:0] sel);
    logic [XLEN-1:0] imm;
    logic            err;
    imm = {XLEN{inst[31]}};
    err = 1'b0;
    case (sel)
      3'b000: imm[11:0] = inst[31:20];
      3'b001: imm[11:0] = {inst[31:25], inst[11:7]};
      3'b010: imm[12:0] = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      3'b011: imm[31:0] = {inst[31:12], 12'b0};
      3'b100: imm[20:0] = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
`ifdef IMM_GEN_ZIMM_EN
      3'b101: begin
        imm      = {XLEN{1'b0}};
        imm[4:0] = inst[19:15];
      end
`endif
      default: begin
        imm = {XLEN{1'b0}};
        err = 1'b1;
      end
    endcase
    return {err, imm};
  endfunction

  logic [XLEN:0]    dec_s;
  logic [XLEN-1:0]  dec_imm_s;
  logic             dec_err_s;
  logic             in_ready_s;
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic             unused_opcode_s;

  logic             main_valid_r;
  logic [XLEN-1:0]  main_imm_r;
  logic [TAG_W-1:0] main_tag_r;
  logic             main_err_r;
  logic [15:0]      err_count_r;

  // Decode the incoming instruction combinationally.
  always_comb begin
    dec_s     = decode_imm(bus.inst[31:7], bus.imm_type);
    dec_imm_s = dec_s[XLEN-1:0];
    dec_err_s = dec_s[XLEN];
  end

  assign unused_opcode_s = ^bus.inst[6:0];
  assign in_xfer_s       = bus.in_valid && in_ready_s;
  assign out_xfer_s      = main_valid_r && bus.out_ready;

  if (SKID) begin : g_skid
    logic             skid_valid_r;
    logic [XLEN-1:0]  skid_imm_r;
    logic [TAG_W-1:0] skid_tag_r;
    logic             skid_err_r;
    logic             in_ready_r;
    logic             skid_next_s;

    // Skid fills when main is stalled and empties when main drains.
    always_comb begin
      skid_next_s = skid_valid_r;
      if (in_xfer_s && main_valid_r && !bus.out_ready) begin
        skid_next_s = 1'b1;
      end else if (out_xfer_s && skid_valid_r) begin
        skid_next_s = 1'b0;
      end else begin
        skid_next_s = skid_valid_r;
      end
    end

    // Main/skid storage and registered in_ready.
    always_ff @(posedge clk) begin
      if (!rst) begin
        main_valid_r <= 1'b0;
        main_imm_r   <= {XLEN{1'b0}};
        main_tag_r   <= {TAG_W{1'b0}};
        main_err_r   <= 1'b0;
        skid_valid_r <= 1'b0;
        skid_imm_r   <= {XLEN{1'b0}};
        skid_tag_r   <= {TAG_W{1'b0}};
        skid_err_r   <= 1'b0;
        in_ready_r   <= 1'b0;
      end else begin
        skid_valid_r <= skid_next_s;
        in_ready_r   <= !skid_next_s;
        if (out_xfer_s && skid_valid_r) begin
          main_imm_r <= skid_imm_r;
          main_tag_r <= skid_tag_r;
          main_err_r <= skid_err_r;
        end else if (in_xfer_s && (!main_valid_r || out_xfer_s)) begin
          main_valid_r <= 1'b1;
          main_imm_r   <= dec_imm_s;
          main_tag_r   <= bus.in_tag;
          main_err_r   <= dec_err_s;
        end else if (out_xfer_s) begin
          main_valid_r <= 1'b0;
        end
        if (in_xfer_s && main_valid_r && !bus.out_ready) begin
          skid_imm_r <= dec_imm_s;
          skid_tag_r <= bus.in_tag;
          skid_err_r <= dec_err_s;
        end
      end
    end

    assign in_ready_s = in_ready_r;
  end else begin : g_single
    // in_ready is held low during reset so nothing is taken while clearing.
    assign in_ready_s = rst && (!main_valid_r || bus.out_ready);

    // Single output register.
    always_ff @(posedge clk) begin
      if (!rst) begin
        main_valid_r <= 1'b0;
        main_imm_r   <= {XLEN{1'b0}};
        main_tag_r   <= {TAG_W{1'b0}};
        main_err_r   <= 1'b0;
      end else if (in_xfer_s) begin
        main_valid_r <= 1'b1;
        main_imm_r   <= dec_imm_s;
        main_tag_r   <= bus.in_tag;
        main_err_r   <= dec_err_s;
      end else if (out_xfer_s) begin
        main_valid_r <= 1'b0;
      end
    end
  end

  // Saturating count of accepted illegal selects.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_count_r <= 16'h0000;
    end else if (in_xfer_s && dec_err_s && (err_count_r != 16'hFFFF)) begin
      err_count_r <= err_count_r + 16'h0001;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = main_valid_r;
  assign bus.ext_imm   = main_imm_r;
  assign bus.out_tag   = main_tag_r;
  assign bus.imm_err   = main_err_r;
  assign err_count     = err_count_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit skid instance and a 64-bit
// single-register instance share clock and reset.
module tb_imm_gen_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a_err;
  logic [15:0] b_err;
  int          checks = 0;
  int          failures = 0;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) a_if ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) b_if ();

  imm_gen_pipe #(.XLEN(32), .TAG_W(5), .SKID(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if), .err_count(a_err)
  );
  imm_gen_pipe #(.XLEN(64), .TAG_W(5), .SKID(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if), .err_count(b_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic a_send(input logic [31:0] inst, input logic [2:0] ty, input logic [4:0] tag);
    a_if.in_valid = 1'b1;
    a_if.inst     = inst;
    a_if.imm_type = ty;
    a_if.in_tag   = tag;
    step();
    a_if.in_valid = 1'b0;
  endtask

  task automatic a_vec(input string tag, input logic [31:0] inst, input logic [2:0] ty,
                       input logic [4:0] tg, input logic [31:0] exp_imm, input logic exp_err);
    a_if.out_ready = 1'b1;
    chk({tag, "_rdy"}, {63'd0, a_if.in_ready}, 64'd1);
    a_send(inst, ty, tg);
    chk({tag, "_vld"}, {63'd0, a_if.out_valid}, 64'd1);
    chk({tag, "_imm"}, {32'd0, a_if.ext_imm}, {32'd0, exp_imm});
    chk({tag, "_err"}, {63'd0, a_if.imm_err}, {63'd0, exp_err});
    chk({tag, "_tag"}, {59'd0, a_if.out_tag}, {59'd0, tg});
    step();
    chk({tag, "_drain"}, {63'd0, a_if.out_valid}, 64'd0);
  endtask

  task automatic b_vec(input string tag, input logic [31:0] inst, input logic [2:0] ty,
                       input logic [4:0] tg, input logic [63:0] exp_imm);
    b_if.out_ready = 1'b1;
    b_if.in_valid  = 1'b1;
    b_if.inst      = inst;
    b_if.imm_type  = ty;
    b_if.in_tag    = tg;
    step();
    b_if.in_valid  = 1'b0;
    chk({tag, "_vld"}, {63'd0, b_if.out_valid}, 64'd1);
    chk({tag, "_imm"}, b_if.ext_imm, exp_imm);
    chk({tag, "_tag"}, {59'd0, b_if.out_tag}, {59'd0, tg});
    step();
  endtask

  initial begin
    rst = 1'b0;
    a_if.in_valid = 1'b0; a_if.inst = 32'd0; a_if.imm_type = 3'd0; a_if.in_tag = 5'd0;
    a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.inst = 32'd0; b_if.imm_type = 3'd0; b_if.in_tag = 5'd0;
    b_if.out_ready = 1'b0;
    step();
    step();
    chk("rst_a_vld", {63'd0, a_if.out_valid}, 64'd0);
    chk("rst_a_rdy", {63'd0, a_if.in_ready}, 64'd0);
    chk("rst_a_imm", {32'd0, a_if.ext_imm}, 64'd0);
    chk("rst_a_cnt", {48'd0, a_err}, 64'd0);
    chk("rst_b_rdy", {63'd0, b_if.in_ready}, 64'd0);
    rst = 1'b1;
    step();
    chk("rel_a_rdy", {63'd0, a_if.in_ready}, 64'd1);
    chk("rel_b_rdy", {63'd0, b_if.in_ready}, 64'd1);

    // Formats on the 32-bit instance.
    a_vec("i_neg", 32'hFFF00093, 3'b000, 5'd7, 32'hFFFFFFFF, 1'b0);
    a_vec("i_pos", 32'h00500093, 3'b000, 5'd8, 32'h00000005, 1'b0);
    a_vec("s_neg", 32'hFE112E23, 3'b001, 5'd9, 32'hFFFFFFFC, 1'b0);
    a_vec("b_neg", 32'hFE000EE3, 3'b010, 5'd10, 32'hFFFFFFFC, 1'b0);
    a_vec("u_pos", 32'h12345037, 3'b011, 5'd11, 32'h12345000, 1'b0);
    a_vec("j_pos", 32'h0080006F, 3'b100, 5'd12, 32'h00000008, 1'b0);
    a_vec("j_neg", 32'hFFDFF06F, 3'b100, 5'd13, 32'hFFFFFFFC, 1'b0);
    a_vec("ill7", 32'hFFFFFFFF, 3'b111, 5'd14, 32'h00000000, 1'b1);
    chk("cnt_ill7", {48'd0, a_err}, 64'd1);
`ifdef IMM_GEN_ZIMM_EN
    a_vec("z_type", 32'h000F8073, 3'b101, 5'd15, 32'h0000001F, 1'b0);
    chk("cnt_z", {48'd0, a_err}, 64'd1);
    a_vec("ill6", 32'hFFFFFFFF, 3'b110, 5'd16, 32'h00000000, 1'b1);
    chk("cnt_ill6", {48'd0, a_err}, 64'd2);
`else
    a_vec("z_type", 32'h000F8073, 3'b101, 5'd15, 32'h00000000, 1'b1);
    chk("cnt_z", {48'd0, a_err}, 64'd2);
    a_vec("ill6", 32'hFFFFFFFF, 3'b110, 5'd16, 32'h00000000, 1'b1);
    chk("cnt_ill6", {48'd0, a_err}, 64'd3);
`endif

    // 64-bit single-register instance.
    b_vec("b64_u", 32'h800000B7, 3'b011, 5'd3, 64'hFFFFFFFF80000000);
    b_vec("b64_i", 32'hFFF00093, 3'b000, 5'd4, 64'hFFFFFFFFFFFFFFFF);
    b_if.out_ready = 1'b0;
    b_if.in_valid = 1'b1; b_if.inst = 32'h00100093; b_if.imm_type = 3'b000; b_if.in_tag = 5'd1;
    step();
    b_if.in_valid = 1'b0;
    chk("b64_stall_rdy", {63'd0, b_if.in_ready}, 64'd0);
    chk("b64_stall_imm", b_if.ext_imm, 64'd1);
    b_if.out_ready = 1'b1;
    #1;
    chk("b64_pass_rdy", {63'd0, b_if.in_ready}, 64'd1);
    step();
    chk("b64_drain", {63'd0, b_if.out_valid}, 64'd0);

    // Backpressure through the skid buffer.
    a_if.out_ready = 1'b0;
    a_send(32'h00100093, 3'b000, 5'd1);
    chk("bp_rdy1", {63'd0, a_if.in_ready}, 64'd1);
    a_if.in_valid = 1'b1; a_if.inst = 32'h00200093; a_if.in_tag = 5'd2;
    step();
    a_if.inst = 32'h00300093; a_if.in_tag = 5'd3;
    chk("bp_full_rdy", {63'd0, a_if.in_ready}, 64'd0);
    chk("bp_head_tag", {59'd0, a_if.out_tag}, 64'd1);
    step();
    chk("bp_hold_rdy", {63'd0, a_if.in_ready}, 64'd0);
    chk("bp_hold_tag", {59'd0, a_if.out_tag}, 64'd1);
    chk("bp_hold_imm", {32'd0, a_if.ext_imm}, 64'd1);
    a_if.out_ready = 1'b1;
    step();
    chk("bp_out2_tag", {59'd0, a_if.out_tag}, 64'd2);
    chk("bp_out2_imm", {32'd0, a_if.ext_imm}, 64'd2);
    chk("bp_reopen", {63'd0, a_if.in_ready}, 64'd1);
    step();
    a_if.in_valid = 1'b0;
    chk("bp_out3_vld", {63'd0, a_if.out_valid}, 64'd1);
    chk("bp_out3_tag", {59'd0, a_if.out_tag}, 64'd3);
    chk("bp_out3_imm", {32'd0, a_if.ext_imm}, 64'd3);
    step();
    chk("bp_empty", {63'd0, a_if.out_valid}, 64'd0);

    // Reset with both entries occupied.
    a_if.out_ready = 1'b0;
    a_send(32'hFFFFFFFF, 3'b111, 5'd4);
    a_send(32'h00400093, 3'b000, 5'd5);
    chk("rs_full", {63'd0, a_if.in_ready}, 64'd0);
    rst = 1'b0;
    step();
    chk("rs_vld", {63'd0, a_if.out_valid}, 64'd0);
    chk("rs_cnt", {48'd0, a_err}, 64'd0);
    chk("rs_rdy", {63'd0, a_if.in_ready}, 64'd0);
    rst = 1'b1;
    step();
    chk("rs_vld_after", {63'd0, a_if.out_valid}, 64'd0);
    a_vec("rs_fresh", 32'h00900093, 3'b000, 5'd9, 32'h00000009, 1'b0);

    // Counter saturation.
    a_if.out_ready = 1'b1;
    a_if.in_valid = 1'b1; a_if.inst = 32'h00000000; a_if.imm_type = 3'b111;
    for (int i = 0; i < 65534; i++) step();
    chk("sat_near", {48'd0, a_err}, 64'hFFFE);
    for (int i = 0; i < 3; i++) step();
    a_if.in_valid = 1'b0;
    chk("sat_hold", {48'd0, a_err}, 64'hFFFF);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Parametrised, pipelined successor to the single-cycle sign extender. Decodes every RV32I immediate format (I, S, B, U, J, plus optional CSR zimm) from a 32-bit instruction and sign-extends it to `XLEN`. Registers the result behind a valid/ready handshake with an optional skid buffer. Sits between fetch/decode and the ALU operand mux in the pipelined core. Carries a sideband tag and counts illegal immediate selects.

## Interface
- `XLEN`, default 32: output width, must be ≥ 32. Sign bit is always `inst[31]`, except for Z-type.
- `TAG_W`, default 5: sideband tag width, e.g. rd index; passed through unmodified.
- `SKID`, default 1: 1 = two-entry skid buffer with registered `in_ready`; 0 = single output register with combinational `in_ready`.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: synchronous, active-low reset.
- `in_valid` input 1: `inst`/`imm_type`/`in_tag` are valid.
- `in_ready` output 1: block accepts the input this cycle.
- `inst` input 32: raw instruction word.
- `imm_type` input 3: format select. 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z (macro only), 110/111 illegal.
- `in_tag` input TAG_W: sideband tag.
- `out_valid` output 1: output holds a result.
- `out_ready` input 1: consumer takes the result this cycle.
- `ext_imm` output XLEN: extended immediate.
- `out_tag` output TAG_W: tag matching `ext_imm`.
- `imm_err` output 1: result came from an illegal `imm_type`.
- `err_count` output 16: saturating count of accepted illegal selects.

## Operation
- Transfers:
  - input transfer = `in_valid && in_ready`;
  - output transfer = `out_valid && out_ready`.
- Formats. Each result is sign-extended from its MSB to XLEN:
  - I: `inst[31:20]`
  - S: `{inst[31:25], inst[11:7]}`
  - B: `{inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}`
  - U: `{inst[31:12], 12'b0}`, then sign-extended
  - J: `{inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}`
- Illegal select: `ext_imm` = 0, `imm_err` = 1, and the result still flows through the pipe in order.
- `err_count` increments by 1 on each input transfer with an illegal select. It saturates at 0xFFFF and never wraps.
- SKID=1 storage:
  - Two entries: main (drives the outputs) and skid.
  - Input transfer while main is empty, or while main is draining and skid is empty → data goes to main.
  - Input transfer while main is stalled → data goes to skid.
  - Output transfer while skid is full → skid moves to main.
  - `in_ready` = skid empty, driven from a register.
- SKID=0 storage: one entry; `in_ready = !out_valid || out_ready`.
- Ordering: strict FIFO; no result is dropped or duplicated.
- Simultaneous input and output transfer: occupancy is unchanged and throughput is 1 per cycle.

## Timing
- Latency: a result accepted in cycle N is visible on `ext_imm`/`out_valid` in cycle N+1.
- Throughput: 1 result/cycle when `out_ready` is held high.
- Output stability: once `out_valid` rises, `ext_imm`, `out_tag` and `imm_err` stay stable until the output transfer.
- While `rst` = 0, at the next edge:
  - `out_valid`=0, `ext_imm`=0, `out_tag`=0, `imm_err`=0, `err_count`=0;
  - skid is emptied;
  - `in_ready`=0 while `rst` is low, and 1 on the first cycle after release.
- Reset mid-stall discards all buffered results and leaves no residual valid.
- Full condition (SKID=1): both entries occupied → `in_ready`=0 in the following cycle. A pending `in_valid` is ignored until `in_ready` is 1.
- `out_ready` may toggle while `out_valid`=0 with no effect.

## Configuration
- `IMM_GEN_ZIMM_EN` defined:
  - `imm_type` 101 selects Z-type: `ext_imm = {(XLEN-5)'b0, inst[19:15]}`, zero-extended, `imm_err`=0.
- Undefined:
  - 101 is illegal: `ext_imm`=0, `imm_err`=1, `err_count` increments.
  - No Z-type logic is present.

## Test plan
- **I-type:** `inst`=0xFFF00093, type 000, `out_ready`=1 → next cycle `ext_imm`=0xFFFFFFFF, `imm_err`=0.
- **B and U types:** B type 010, `inst`=0xFE000EE3 → 0xFFFFFFFC. U type 011, `inst`=0x800000B7, XLEN=64 → 0xFFFFFFFF80000000.
- **Backpressure (SKID=1):**
  - Stimulus: `out_ready`=0, three back-to-back inputs with tags 1, 2, 3.
  - Response: tags 1 and 2 accepted; `in_ready`=0 from the cycle after the second accept.
  - Then raise `out_ready`: tags come out 1, 2, then 3 after it is accepted; no gaps beyond one bubble.
- **Illegal select:** type 111 → `ext_imm`=0, `imm_err`=1, `err_count`=1. Preload 0xFFFF illegal transfers → `err_count` stays 0xFFFF.
- **Z-type:**
  - Type 101 with `inst[19:15]`=5'h1F and the macro defined → `ext_imm`=0x0000001F, `imm_err`=0.
  - Same stimulus without the macro → `ext_imm`=0, `imm_err`=1.
- **Reset mid-stall:** both entries full, then assert `rst`=0 for 1 cycle → `out_valid`=0, `err_count`=0; after release, `in_ready`=1 and a fresh input appears with 1-cycle latency.
